fir_mode_sequencer: RTL and testbench

Controller that owns the configuration and sample gating of one fir_flux_filter instance. It accepts a mode-change request from the host register interface and quiesces the filter's input stream. It drains the filter pipeline, streams staged coefficients into the filter for adaptive mode, switches the mode, and masks the filter's output until the new impulse response has settled. It sits between the ADC sample stream, the host CSR block and the FIR datapath.

---
 rtl/fir_mode_sequencer.sv | 90 +++++++++
 tb/tb_fir_mode_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fir_mode_sequencer.sv
// fir_mode_sequencer: quiesces, reloads and mode-switches one FIR filter on host commit requests
module fir_mode_sequencer #(
  parameter int DATA_WIDTH = 12,
  parameter int COEF_WIDTH = 16,
  parameter int NUM_TAPS = 16,
  parameter int DRAIN_CYCLES = 8,
  parameter int SETTLE_SAMPLES = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cfg_enable,
  input  logic                        cfg_we,
  input  logic [$clog2(NUM_TAPS)-1:0] cfg_addr,
  input  logic [COEF_WIDTH-1:0]       cfg_wdata,
  input  logic [1:0]                  cfg_mode,
  input  logic                        cfg_commit,
  output logic                        cfg_busy,
  output logic                        cfg_done,
  output logic                        cfg_err,
  input  logic [DATA_WIDTH-1:0]       s_data,
  input  logic                        s_valid,
  output logic                        fir_enable,
  output logic [DATA_WIDTH-1:0]       fir_data_in,
  output logic                        fir_data_valid,
  output logic [1:0]                  fir_mode,
  output logic                        fir_coef_load,
  output logic [$clog2(NUM_TAPS)-1:0] fir_coef_addr,
  output logic [COEF_WIDTH-1:0]       fir_coef_data,
  input  logic                        fir_out_valid,
  output logic                        out_valid,
  output logic [15:0]                 drop_count
);
  localparam int AW = $clog2(NUM_TAPS);
  localparam int M1 = DRAIN_CYCLES > NUM_TAPS ? DRAIN_CYCLES : NUM_TAPS;
  localparam int MAXC = M1 > SETTLE_SAMPLES ? M1 : SETTLE_SAMPLES;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic [2:0] {IDLE, RUN, QUIESCE, LOAD, SWITCH, SETTLE} state_t;
  state_t state, state_next;
  logic [CW-1:0] cnt;
  logic [1:0] req_mode;
  logic [COEF_WIDTH-1:0] staging [NUM_TAPS];
  logic accept, dropping;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = (cfg_enable && cfg_commit) ? QUIESCE : IDLE;
      RUN:     state_next = !cfg_enable ? IDLE : cfg_commit ? QUIESCE : RUN;
      QUIESCE: state_next = (cnt == CW'(DRAIN_CYCLES - 1)) ? (req_mode == 2'b11 ? LOAD : SWITCH) : QUIESCE;
      LOAD:    state_next = (cnt == CW'(NUM_TAPS - 1)) ? SWITCH : LOAD;
      SWITCH:  state_next = SETTLE;
      SETTLE:  state_next = (fir_out_valid && cnt == CW'(SETTLE_SAMPLES - 1)) ? (cfg_enable ? RUN : IDLE) : SETTLE;
      default: state_next = IDLE;
    endcase
  end
  assign accept = (state == IDLE || state == RUN) && state_next == QUIESCE;
  assign dropping = state == QUIESCE || state == LOAD || state == SWITCH;
  assign cfg_busy = state != IDLE && state != RUN;
  assign fir_enable = state != IDLE;
  assign out_valid = fir_out_valid && state == RUN;
  assign fir_coef_load = state == LOAD;
  assign fir_coef_addr = fir_coef_load ? cnt[AW-1:0] : '0;
  assign fir_coef_data = fir_coef_load ? staging[fir_coef_addr] : '0;
  always_ff @(posedge clk) begin
    if (cfg_we && state != LOAD) staging[cfg_addr] <= cfg_wdata;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      req_mode <= '0;
      fir_mode <= '0;
      fir_data_in <= '0;
      fir_data_valid <= 1'b0;
      cfg_done <= 1'b0;
      cfg_err <= 1'b0;
      drop_count <= '0;
    end else begin
      state <= state_next;
      cnt <= (state_next != state) ? '0 :
             (state == QUIESCE || state == LOAD || (state == SETTLE && fir_out_valid)) ? cnt + 1'b1 : cnt;
      if (accept) req_mode <= cfg_mode;
      if (state_next == SWITCH) fir_mode <= req_mode;
      fir_data_in <= s_data;
      fir_data_valid <= s_valid && (state == RUN || state == SETTLE);
      cfg_done <= state == SETTLE && state_next != SETTLE;
      if (cfg_commit && cfg_busy) cfg_err <= 1'b1;
      if (s_valid && dropping && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_fir_mode_sequencer.sv
// tb_fir_mode_sequencer: scoreboard bench for the FIR mode sequencer
module tb_fir_mode_sequencer;
  logic clk = 1'b0;
  logic reset, cfg_enable, cfg_we, cfg_commit, s_valid, fir_out_valid;
  logic [3:0] cfg_addr;
  logic [15:0] cfg_wdata;
  logic [1:0] cfg_mode;
  logic [11:0] s_data;
  logic cfg_busy, cfg_done, cfg_err, fir_enable, fir_data_valid, fir_coef_load, out_valid;
  logic [11:0] fir_data_in;
  logic [1:0] fir_mode;
  logic [3:0] fir_coef_addr;
  logic [15:0] fir_coef_data, drop_count;
  logic [19:0] coef_q[$];
  logic [1:0] done_q[$];
  int errors = 0;
  int checks = 0;
  int fdv = 0;
  always #5 clk = ~clk;
  fir_mode_sequencer dut (
    .clk(clk), .reset(reset), .cfg_enable(cfg_enable), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_mode(cfg_mode), .cfg_commit(cfg_commit), .cfg_busy(cfg_busy),
    .cfg_done(cfg_done), .cfg_err(cfg_err), .s_data(s_data), .s_valid(s_valid),
    .fir_enable(fir_enable), .fir_data_in(fir_data_in), .fir_data_valid(fir_data_valid),
    .fir_mode(fir_mode), .fir_coef_load(fir_coef_load), .fir_coef_addr(fir_coef_addr),
    .fir_coef_data(fir_coef_data), .fir_out_valid(fir_out_valid), .out_valid(out_valid),
    .drop_count(drop_count)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic step_acc(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      fdv += int'(fir_data_valid);
    end
  endtask
  always @(negedge clk) begin
    if (fir_coef_load) begin
      if (coef_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL coef_unexpected: got addr %0h data %0h expected no load", fir_coef_addr, fir_coef_data);
      end else begin
        logic [19:0] e;
        e = coef_q.pop_front();
        check("coef_addr", 32'(fir_coef_addr), 32'(e[19:16]));
        check("coef_data", 32'(fir_coef_data), 32'(e[15:0]));
      end
    end
    if (cfg_done) begin
      if (done_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: got cfg_done=1 expected 0");
      end else begin
        logic [1:0] m;
        m = done_q.pop_front();
        check("done_mode", 32'(fir_mode), 32'(m));
      end
    end
  end
  initial begin
    int n;
    reset = 1'b1; cfg_enable = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    cfg_mode = '0; cfg_commit = 1'b0; s_data = 12'h123; s_valid = 1'b0; fir_out_valid = 1'b1;
    repeat (5) step();
    check("rst_fir_enable", 32'(fir_enable), 0);
    check("rst_fir_mode", 32'(fir_mode), 0);
    check("rst_busy", 32'(cfg_busy), 0);
    check("rst_drop", 32'(drop_count), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_coef_load", 32'(fir_coef_load), 0);
    check("rst_err", 32'(cfg_err), 0);
    reset = 1'b0; fir_out_valid = 1'b0;
    step();
    cfg_enable = 1'b1; cfg_mode = 2'b01; cfg_commit = 1'b1; s_valid = 1'b1;
    done_q.push_back(2'b01);
    step();
    cfg_commit = 1'b0;
    check("m01_busy_s1", 32'(cfg_busy), 1);
    n = 0;
    while (cfg_busy && fir_mode == 2'b00 && n < 20) begin
      n++;
      step();
    end
    check("m01_drain_cycles", 32'(n), 8);
    check("m01_mode_switch", 32'(fir_mode), 32'h1);
    check("m01_busy_switch", 32'(cfg_busy), 1);
    step();
    check("m01_drop", 32'(drop_count), 9);
    check("m01_fdv_blocked", 32'(fir_data_valid), 0);
    fir_out_valid = 1'b1;
    step();
    check("m01_fdv_settle", 32'(fir_data_valid), 1);
    check("m01_out_masked", 32'(out_valid), 0);
    repeat (15) step();
    check("m01_busy_run", 32'(cfg_busy), 0);
    check("m01_out_run", 32'(out_valid), 1);
    fir_out_valid = 1'b0;
    #1;
    check("m01_out_follow", 32'(out_valid), 0);
    step();
    cfg_enable = 1'b0; cfg_commit = 1'b1; cfg_mode = 2'b10; s_valid = 1'b0;
    step();
    cfg_commit = 1'b0;
    check("ewin_enable", 32'(fir_enable), 0);
    check("ewin_busy", 32'(cfg_busy), 0);
    check("ewin_err", 32'(cfg_err), 0);
    cfg_enable = 1'b1; cfg_commit = 1'b1;
    done_q.push_back(2'b10);
    step();
    cfg_commit = 1'b0; cfg_enable = 1'b0;
    check("m10_busy", 32'(cfg_busy), 1);
    repeat (8) step();
    check("m10_mode", 32'(fir_mode), 32'h2);
    step();
    fir_out_valid = 1'b1;
    repeat (16) step();
    check("m10_idle_enable", 32'(fir_enable), 0);
    check("m10_idle_busy", 32'(cfg_busy), 0);
    check("m10_idle_out", 32'(out_valid), 0);
    fir_out_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cfg_we = 1'b1; cfg_addr = 4'(i); cfg_wdata = 16'h0800 + 16'(i);
      coef_q.push_back({i[3:0], 16'h0800 + 16'(i)});
      step();
    end
    cfg_we = 1'b0;
    cfg_enable = 1'b1; cfg_mode = 2'b11; cfg_commit = 1'b1; s_valid = 1'b1;
    done_q.push_back(2'b11);
    step();
    cfg_commit = 1'b0;
    fdv = int'(fir_data_valid);
    step_acc(11);
    cfg_commit = 1'b1; cfg_mode = 2'b01; cfg_we = 1'b1; cfg_addr = 4'd3; cfg_wdata = 16'hDEAD;
    step_acc(1);
    cfg_commit = 1'b0; cfg_we = 1'b0;
    check("m11_err", 32'(cfg_err), 1);
    step_acc(11);
    check("m11_last_load", 32'(fir_coef_load), 1);
    check("m11_last_addr", 32'(fir_coef_addr), 15);
    step_acc(1);
    check("m11_mode", 32'(fir_mode), 32'h3);
    check("m11_load_off", 32'(fir_coef_load), 0);
    step_acc(1);
    check("m11_drop", 32'(drop_count), 34);
    check("m11_fdv_blocked", 32'(fdv), 0);
    fir_out_valid = 1'b1;
    step();
    check("m11_fdv_settle", 32'(fir_data_valid), 1);
    check("m11_out_masked", 32'(out_valid), 0);
    fir_out_valid = 1'b0;
    step();
    for (int i = 0; i < 15; i++) begin
      fir_out_valid = 1'b1;
      step();
      fir_out_valid = 1'b0;
      step();
    end
    check("m11_busy_run", 32'(cfg_busy), 0);
    check("m11_enable_run", 32'(fir_enable), 1);
    check("m11_err_sticky", 32'(cfg_err), 1);
    check("m11_coefq_empty", 32'(coef_q.size()), 0);
    s_valid = 1'b0; cfg_mode = 2'b11; cfg_commit = 1'b1;
    for (int i = 0; i < 8; i++) coef_q.push_back({i[3:0], 16'h0800 + 16'(i)});
    step();
    cfg_commit = 1'b0;
    check("same_busy", 32'(cfg_busy), 1);
    repeat (15) step();
    check("same_load7", 32'(fir_coef_load), 1);
    check("same_addr7", 32'(fir_coef_addr), 7);
    reset = 1'b1;
    step();
    check("rstld_load", 32'(fir_coef_load), 0);
    check("rstld_busy", 32'(cfg_busy), 0);
    check("rstld_drop", 32'(drop_count), 0);
    check("rstld_enable", 32'(fir_enable), 0);
    check("rstld_mode", 32'(fir_mode), 0);
    check("rstld_err", 32'(cfg_err), 0);
    reset = 1'b0;
    repeat (4) step();
    check("end_load", 32'(fir_coef_load), 0);
    check("end_coefq_empty", 32'(coef_q.size()), 0);
    check("end_doneq_empty", 32'(done_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
